// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider; clk/rst, start/annul/signed, operands in, {rem,quo}/ready/stallreq out
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_DBZ = 2'd1, S_ON = 2'd2, S_END = 2'd3;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, dvs, rem, mag1, mag2, q_fix, r_fix;
  logic [WIDTH:0]   trial, diff;
  logic             neg_q, neg_r, s1, s2;
  assign s1 = signed_div_i & opdata1_i[WIDTH-1];
  assign s2 = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1 = s1 ? -opdata1_i : opdata1_i;
  assign mag2 = s2 ? -opdata2_i : opdata2_i;
  assign trial = {rem, quo[WIDTH-1]};
  assign diff = trial - {1'b0, dvs};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;
  assign stallreq_o = start_i & ~ready_o;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_i && !annul_i) begin
          quo   <= mag1;
          dvs   <= mag2;
          rem   <= '0;
          cnt   <= '0;
          neg_q <= s1 ^ s2;
          neg_r <= s1;
          state <= (opdata2_i == '0) ? S_DBZ : S_ON;
        end
        S_DBZ: begin
          result_o <= '0;
          ready_o  <= 1'b1;
          state    <= S_END;
        end
        S_ON: if (annul_i) begin
          result_o <= '0;
          state    <= S_IDLE;
        end else if (cnt == CW'(WIDTH)) begin
          result_o <= {r_fix, q_fix};
          ready_o  <= 1'b1;
          state    <= S_END;
        end else begin
          rem <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        default: if (!start_i) begin
          result_o <= '0;
          ready_o  <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed self-checking bench for div_unit
module tb_div_unit;
  logic        clk = 0, rst, start_i, annul_i, signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;
  int          checks = 0, errors = 0;
  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
    .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [63:0] exp;
    int lat, exp_lat;
    exp = model(a, b, s);
    exp_lat = (b == 0) ? 2 : 34;
    lat = -1;
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = s;
    start_i = 1;
    #1 check("stall_c0", stallreq_o, 1);
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = 1'($urandom);
      check("stall", stallreq_o, k < exp_lat);
      if (ready_o) lat = k;
    end
    check("latency", lat, exp_lat);
    check("result", result_o, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_ready", ready_o, 1);
      check("hold_result", result_o, exp);
      check("hold_stall", stallreq_o, 0);
    end
    start_i = 0;
    @(negedge clk);
    check("drop_ready", ready_o, 0);
    check("drop_result", result_o, 0);
  endtask
  initial begin
    logic seen;
    logic [31:0] a, b;
    rst = 1; start_i = 0; annul_i = 0; signed_div_i = 0; opdata1_i = 0; opdata2_i = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 0);
    check("rst_result", result_o, 0);
    check("rst_stall", stallreq_o, 0);
    rst = 0;
    @(negedge clk);
    run_div(32'd100, 32'd7, 0, 0);
    run_div(-32'd7, 32'd2, 1, 0);
    run_div(32'd7, -32'd2, 1, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_div(32'd5, 32'd0, 1, 5);
    start_i = 1; annul_i = 1; opdata1_i = 9; opdata2_i = 3;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen |= ready_o;
    end
    check("idle_annul_stall", stallreq_o, 1);
    start_i = 0; annul_i = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready_o;
    end
    check("idle_annul_ready", seen, 0);
    opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 0; start_i = 1;
    repeat (10) @(negedge clk);
    annul_i = 1; start_i = 0;
    @(negedge clk);
    annul_i = 0;
    check("annul_ready", ready_o, 0);
    check("annul_result", result_o, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= ready_o;
    end
    check("annul_never_ready", seen, 0);
    check("annul_result_late", result_o, 0);
    run_div(32'd1000, 32'd3, 0, 1);
    opdata1_i = 32'd12345; opdata2_i = 32'd17; signed_div_i = 0; start_i = 1;
    repeat (20) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("midrst_ready", ready_o, 0);
    check("midrst_result", result_o, 0);
    check("midrst_stall", stallreq_o, 1);
    rst = 0; start_i = 0;
    @(negedge clk);
    run_div(32'd12345, 32'd17, 0, 0);
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      run_div(a, b, 1'($urandom), $urandom_range(0, 2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
